// File: rtl/zeroriscy_lsu_pkg.sv
// Shared types and helpers for the zero-riscy split load/store unit.
// Size decode, byte-enable, write-rotate and load-extend helpers.
package zeroriscy_lsu_pkg;

  typedef enum logic [1:0] {
    LSU_WORD = 2'b00,
    LSU_HALF = 2'b01,
    LSU_BYTE = 2'b10
  } lsu_type_e;

  typedef enum logic {
    S_IDLE,
    S_SECOND
  } lsu_state_e;

  typedef struct packed {
    lsu_type_e  typ;
    logic [1:0] off;
    logic       sign_ext;
    logic       we;
    logic       split;
    logic       first;
  } lsu_meta_t;

  localparam logic [3:0] SIZE_MASK_WORD = 4'b1111;
  localparam logic [3:0] SIZE_MASK_HALF = 4'b0011;
  localparam logic [3:0] SIZE_MASK_BYTE = 4'b0001;

  function automatic lsu_type_e lsu_to_type(
    input logic [1:0] t
  );
    lsu_type_e r;
    r = LSU_WORD;
    unique case (1'b1)
      t[1]:           r = LSU_BYTE;
      (t == 2'b01):   r = LSU_HALF;
      default:        r = LSU_WORD;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] lsu_size_mask(
    input lsu_type_e t
  );
    logic [3:0] m;
    m = SIZE_MASK_WORD;
    unique case (1'b1)
      (t == LSU_HALF): m = SIZE_MASK_HALF;
      (t == LSU_BYTE): m = SIZE_MASK_BYTE;
      default:         m = SIZE_MASK_WORD;
    endcase
    return m;
  endfunction

  // Low nibble enables part 1, high nibble part 2.
  function automatic logic [7:0] lsu_be_wide(
    input lsu_type_e  t,
    input logic [1:0] off
  );
    logic [7:0] m;
    m = {4'b0000, lsu_size_mask(t)};
    return m << off;
  endfunction

  function automatic logic lsu_misaligned(
    input lsu_type_e  t,
    input logic [1:0] off
  );
    return ((t == LSU_WORD) && (off != 2'b00)) ||
           ((t == LSU_HALF) && (off == 2'b11));
  endfunction

  function automatic logic [31:0] lsu_wdata_rot(
    input lsu_type_e   t,
    input logic [1:0]  off,
    input logic [31:0] w
  );
    logic [31:0] rep;
    logic [63:0] d;
    rep = w;
    unique case (1'b1)
      (t == LSU_HALF): rep = {2{w[15:0]}};
      (t == LSU_BYTE): rep = {4{w[7:0]}};
      default:         rep = w;
    endcase
    d = {rep, rep} << {off, 3'b000};
    return 32'(d >> 32);
  endfunction

  function automatic logic [31:0] lsu_extend(
    input lsu_type_e   t,
    input logic        sx,
    input logic [31:0] w
  );
    logic [31:0] r;
    r = w;
    unique case (1'b1)
      (t == LSU_HALF): r = {{16{sx & w[15]}}, w[15:0]};
      (t == LSU_BYTE): r = {{24{sx & w[7]}}, w[7:0]};
      default:         r = w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/zeroriscy_lsu_meta_fifo.sv
// In-order metadata FIFO tracking bus transactions in flight.
// Push on bus grant, pop on bus response.
module zeroriscy_lsu_meta_fifo
  import zeroriscy_lsu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push,
  input  logic       i_pop,
  input  lsu_meta_t  i_data,
  output lsu_meta_t  o_head,
  output logic       o_full,
  output logic       o_empty,
  output logic [3:0] o_count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  lsu_meta_t       r_mem [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [3:0]      r_count;
  logic            w_push;
  logic            w_pop;

  function automatic logic [PW-1:0] ptr_inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full  = (r_count == 4'(DEPTH));
  assign o_empty = (r_count == 4'd0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rptr];

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= 4'd0;
    end else begin
      if (w_push) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)  r_rptr <= ptr_inc(r_rptr);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 4'd1;
        2'b01:   r_count <= r_count - 4'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

endmodule

// File: rtl/zeroriscy_lsu_split.sv
// zero-riscy load/store unit with misaligned split and response merge.
// Up to MAX_OUTSTANDING bus transactions tracked in order.
module zeroriscy_lsu_split
  import zeroriscy_lsu_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter bit          SPLIT_EN        = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic        data_err_i,
  output logic [31:0] data_addr_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  input  logic [31:0] data_rdata_i,
  input  logic        data_req_ex_i,
  input  logic        data_we_ex_i,
  input  logic [1:0]  data_type_ex_i,
  input  logic        data_sign_ext_ex_i,
  input  logic [31:0] data_wdata_ex_i,
  input  logic [31:0] adder_result_ex_i,
  output logic        data_gnt_ex_o,
  output logic        data_valid_o,
  output logic [31:0] data_rdata_ex_o,
  output logic        load_err_o,
  output logic        store_err_o,
  output logic        busy_o
);

  lsu_state_e  r_state;
  lsu_state_e  w_state_nxt;
  lsu_type_e   w_type;
  logic [1:0]  w_off;
  logic        w_split;
  logic [7:0]  w_be;
  logic [31:0] w_addr_lo;
  logic        w_first_part;
  logic        w_push;
  logic        w_pop;
  logic        w_resp_first;
  lsu_meta_t   w_push_meta;
  lsu_meta_t   w_head;
  logic        w_full;
  logic        w_empty;
  logic [3:0]  w_count;
  logic [31:0] r_rdata_lo;
  logic        r_err;
  logic [63:0] w_cat;
  logic [31:0] w_merged;
  logic        w_err;

  assign w_type    = lsu_to_type(data_type_ex_i);
  assign w_off     = adder_result_ex_i[1:0];
  assign w_split   = SPLIT_EN && lsu_misaligned(w_type, w_off);
  assign w_be      = lsu_be_wide(w_type, w_off);
  assign w_addr_lo = {adder_result_ex_i[31:2], 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (w_push && w_split) w_state_nxt = S_SECOND;
      S_SECOND: if (w_push) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    data_req_o    = 1'b0;
    data_addr_o   = w_addr_lo;
    data_be_o     = w_be[3:0];
    data_gnt_ex_o = 1'b0;
    w_first_part  = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        data_req_o    = data_req_ex_i && !w_full;
        data_gnt_ex_o = data_req_ex_i && !w_full &&
                        data_gnt_i && !w_split;
      end
      S_SECOND: begin
        data_req_o    = !w_full;
        data_addr_o   = w_addr_lo + 32'd4;
        data_be_o     = w_be[7:4];
        data_gnt_ex_o = !w_full && data_gnt_i;
        w_first_part  = 1'b0;
      end
      default: ;
    endcase
  end

  assign data_we_o    = data_we_ex_i;
  assign data_wdata_o = lsu_wdata_rot(w_type, w_off, data_wdata_ex_i);
  assign w_push       = data_req_o && data_gnt_i;

  assign w_push_meta = '{
    typ:      w_type,
    off:      w_off,
    sign_ext: data_sign_ext_ex_i,
    we:       data_we_ex_i,
    split:    w_split,
    first:    w_first_part
  };

  zeroriscy_lsu_meta_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_meta_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_push_meta),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Responses with nothing outstanding are dropped.
  assign w_pop        = data_rvalid_i && !w_empty;
  assign w_resp_first = w_pop && w_head.split && w_head.first;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata_lo <= 32'd0;
      r_err      <= 1'b0;
    end else if (w_resp_first) begin
      r_rdata_lo <= data_rdata_i;
      r_err      <= data_err_i;
    end
  end

  assign w_cat = w_head.split ? {data_rdata_i, r_rdata_lo}
                              : {32'd0, data_rdata_i};
  assign w_merged = 32'(w_cat >> {w_head.off, 3'b000});
  assign w_err    = data_err_i | (w_head.split & r_err);

  assign data_valid_o    = w_pop && !w_resp_first;
  assign data_rdata_ex_o = lsu_extend(w_head.typ, w_head.sign_ext, w_merged);
  assign load_err_o      = data_valid_o && !w_head.we && w_err;
  assign store_err_o     = data_valid_o && w_head.we && w_err;
  assign busy_o          = !w_empty || data_req_o;

  logic w_count_unused;
  assign w_count_unused = ^w_count;

  a_rvalid_outstanding: assert property (
    @(posedge clk) disable iff (!rst_n)
    data_rvalid_i |-> !w_empty
  );

endmodule
